// File: rtl/mixer_duc_nco_lut.sv
// Purpose: NCO giving signed 8-bit cos/sin coefficients for the DUC I/Q mixer multipliers.
// Latency: 3 ce edges from accumulator phase to cos_out/sin_out; out_valid follows the same pipeline depth.
// Backpressure: none; ce=0 freezes accumulator, pipeline and valid (freq_we still loads the increment).
module mixer_duc_nco_lut #(
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               freq_we,
    input  logic [7:0]         phase_offset,
    input  logic               phase_clr,
    output logic [7:0]         cos_out,
    output logic [7:0]         sin_out,
    output logic               out_valid
);

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] inc_reg;
    logic [7:0]         ph;
    logic [6:0]         sin_mag;
    logic [6:0]         cos_mag;
    logic               sin_neg;
    logic               cos_neg;
    logic [2:0]         vld_sr;
    logic [7:0]         sin_fold;
    logic [7:0]         cos_fold;

    // Quarter-wave table: round(127*sin(pi*k/128)), k = 0..64.
    function automatic logic [6:0] qtr_sin(input logic [LUT_AW:0] k);
        logic [6:0] v;
        case (k)
            7'd0:  v = 7'd0;   7'd1:  v = 7'd3;   7'd2:  v = 7'd6;   7'd3:  v = 7'd9;
            7'd4:  v = 7'd12;  7'd5:  v = 7'd16;  7'd6:  v = 7'd19;  7'd7:  v = 7'd22;
            7'd8:  v = 7'd25;  7'd9:  v = 7'd28;  7'd10: v = 7'd31;  7'd11: v = 7'd34;
            7'd12: v = 7'd37;  7'd13: v = 7'd40;  7'd14: v = 7'd43;  7'd15: v = 7'd46;
            7'd16: v = 7'd49;  7'd17: v = 7'd51;  7'd18: v = 7'd54;  7'd19: v = 7'd57;
            7'd20: v = 7'd60;  7'd21: v = 7'd63;  7'd22: v = 7'd65;  7'd23: v = 7'd68;
            7'd24: v = 7'd71;  7'd25: v = 7'd73;  7'd26: v = 7'd76;  7'd27: v = 7'd78;
            7'd28: v = 7'd81;  7'd29: v = 7'd83;  7'd30: v = 7'd85;  7'd31: v = 7'd88;
            7'd32: v = 7'd90;  7'd33: v = 7'd92;  7'd34: v = 7'd94;  7'd35: v = 7'd96;
            7'd36: v = 7'd98;  7'd37: v = 7'd100; 7'd38: v = 7'd102; 7'd39: v = 7'd104;
            7'd40: v = 7'd106; 7'd41: v = 7'd107; 7'd42: v = 7'd109; 7'd43: v = 7'd111;
            7'd44: v = 7'd112; 7'd45: v = 7'd113; 7'd46: v = 7'd115; 7'd47: v = 7'd116;
            7'd48: v = 7'd117; 7'd49: v = 7'd118; 7'd50: v = 7'd120; 7'd51: v = 7'd121;
            7'd52: v = 7'd122; 7'd53: v = 7'd122; 7'd54: v = 7'd123; 7'd55: v = 7'd124;
            7'd56: v = 7'd125; 7'd57: v = 7'd125; 7'd58: v = 7'd126; 7'd59: v = 7'd126;
            7'd60: v = 7'd126; 7'd61: v = 7'd127; 7'd62: v = 7'd127; 7'd63: v = 7'd127;
            default: v = 7'd127;
        endcase
        return v;
    endfunction

    // Quadrant fold of an 8-bit phase into {negative, magnitude}: odd quadrants mirror the
    // index, the upper half-circle flips the sign.
    function automatic logic [7:0] fold(input logic [7:0] p);
        logic [LUT_AW-1:0] k;
        logic [LUT_AW:0]   idx;
        k   = p[LUT_AW-1:0];
        idx = p[6] ? (7'd64 - {1'b0, k}) : {1'b0, k};
        return {p[7], qtr_sin(idx)};
    endfunction

    // Cosine is the sine a quarter turn ahead, so both share the same fold.
    always_comb begin
        sin_fold = fold(ph);
        cos_fold = fold(ph + 8'd64);
    end

    // Increment register loads on any edge; the accumulator only sees the new value from the next ce edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_reg <= '0;
        end else if (freq_we) begin
            inc_reg <= freq_word;
        end
    end

    // Phase accumulator, wrapping modulo 2^PHASE_W; phase_clr only acts on ce edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (ce) begin
            acc <= phase_clr ? '0 : acc + inc_reg;
        end
    end

    // Three-stage table pipeline plus its valid shift register, all frozen while ce is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph        <= '0;
            sin_mag   <= '0;
            cos_mag   <= '0;
            sin_neg   <= 1'b0;
            cos_neg   <= 1'b0;
            sin_out   <= '0;
            cos_out   <= '0;
            vld_sr    <= '0;
        end else if (ce) begin
            ph      <= acc[PHASE_W-1 -: 8] + phase_offset;
            sin_neg <= sin_fold[7];
            sin_mag <= sin_fold[6:0];
            cos_neg <= cos_fold[7];
            cos_mag <= cos_fold[6:0];
            sin_out <= sin_neg ? (8'd0 - {1'b0, sin_mag}) : {1'b0, sin_mag};
            cos_out <= cos_neg ? (8'd0 - {1'b0, cos_mag}) : {1'b0, cos_mag};
            vld_sr  <= {vld_sr[1:0], 1'b1};
        end
    end

    assign out_valid = vld_sr[2];

endmodule

// File: tb/tb_mixer_duc_nco_lut.sv
// Purpose: self-checking bench for mixer_duc_nco_lut against a real-arithmetic sine reference.
// Latency: expects each sample 3 ce edges after its accumulator phase; valid from the 3rd ce edge.
// Backpressure: exercises ce gaps, async reset mid-run and phase clears under random stimulus.
module tb_mixer_duc_nco_lut;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic [23:0] freq_word = '0;
    logic        freq_we = 1'b0;
    logic [7:0]  phase_offset = '0;
    logic        phase_clr = 1'b0;
    logic [7:0]  cos_out;
    logic [7:0]  sin_out;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    // Reference state: accumulator, increment, ce-edge count and the table phase of every ce edge.
    logic [23:0] m_acc = '0;
    logic [23:0] m_inc = '0;
    int          cnt = 0;
    int          ph_hist[$];

    mixer_duc_nco_lut #(.PHASE_W(24), .LUT_AW(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .freq_word    (freq_word),
        .freq_we      (freq_we),
        .phase_offset (phase_offset),
        .phase_clr    (phase_clr),
        .cos_out      (cos_out),
        .sin_out      (sin_out),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // 127*sin(2*pi*ph/256), rounded half away from zero.
    function automatic int ref_sin(input int ph);
        real x;
        x = 127.0 * $sin(2.0 * 3.14159265358979 * real'(ph % 256) / 256.0);
        if (x >= 0.0) return int'($floor(x + 0.5));
        else          return -int'($floor(-x + 0.5));
    endfunction

    task automatic check_outputs();
        int p;
        chk("out_valid", int'(out_valid), (cnt >= 3) ? 1 : 0);
        chk("sin_not_m128", int'(sin_out == 8'h80), 0);
        chk("cos_not_m128", int'(cos_out == 8'h80), 0);
        if (cnt >= 3) begin
            p = ph_hist[cnt-3];
            chk("sin", int'($signed(sin_out)), ref_sin(p));
            chk("cos", int'($signed(cos_out)), ref_sin(p + 64));
        end else if (cnt < 2) begin
            chk("sin_pre", int'($signed(sin_out)), 0);
            chk("cos_pre", int'($signed(cos_out)), 0);
        end
    endtask

    task automatic model_reset();
        m_acc = '0;
        m_inc = '0;
        cnt   = 0;
        ph_hist.delete();
    endtask

    task automatic step(input logic c, input logic we, input logic [23:0] fw,
                        input logic [7:0] off, input logic clr);
        logic [7:0] p;
        ce = c; freq_we = we; freq_word = fw; phase_offset = off; phase_clr = clr;
        @(posedge clk);
        if (c) begin
            p = m_acc[23:16] + off;
            ph_hist.push_back(int'(p));
            m_acc = clr ? 24'd0 : m_acc + m_inc;
            cnt++;
        end
        if (we) m_inc = fw;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sin", int'(sin_out), 0);
        chk("rst_cos", int'(cos_out), 0);
        reset = 1'b0;
        model_reset();
    endtask

    int off_tab[4] = '{16, 32, 64, 128};
    int sin_tab[4] = '{49, 90, 127, 0};
    int cos_tab[4] = '{117, 90, 0, -127};

    initial begin
        #12 reset = 1'b0;
        chk("init_valid", int'(out_valid), 0);
        chk("init_sin", int'(sin_out), 0);
        chk("init_cos", int'(cos_out), 0);

        // Idle oscillator: inc_reg=0, offset 0 -> (127, 0) once valid.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 24'd0, 8'd0, 1'b0);
            if (i == 2) begin
                chk("idle_cos", int'($signed(cos_out)), 127);
                chk("idle_sin", int'($signed(sin_out)), 0);
            end
        end

        // Pure phase offsets with zero increment, checked against known table points.
        for (int j = 0; j < 4; j++) begin
            do_reset();
            for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 24'd0, 8'(off_tab[j]), 1'b0);
            chk("off_sin", int'($signed(sin_out)), sin_tab[j]);
            chk("off_cos", int'($signed(cos_out)), cos_tab[j]);
        end

        // Quarter-turn steps, then the same with ce gaps (1,0,0 pattern).
        do_reset();
        step(1'b0, 1'b1, 24'h400000, 8'd0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 24'd0, 8'd0, 1'b0);
        for (int i = 0; i < 30; i++) step((i % 3) == 0, 1'b0, 24'd0, 8'd0, 1'b0);

        // Fine steps covering every table phase, then a phase clear mid-run.
        step(1'b1, 1'b1, 24'h010000, 8'd0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 24'd0, 8'd0, 1'b0);
        step(1'b1, 1'b0, 24'd0, 8'd0, 1'b1);
        step(1'b1, 1'b0, 24'd0, 8'd0, 1'b0);
        step(1'b1, 1'b0, 24'd0, 8'd0, 1'b0);
        step(1'b1, 1'b0, 24'd0, 8'd0, 1'b0);
        chk("clr_cos", int'($signed(cos_out)), 127);
        chk("clr_sin", int'($signed(sin_out)), 0);
        chk("clr_valid", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 24'd0, 8'd0, 1'b0);

        // Random operation with an asynchronous reset dropped in mid-run.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                 24'($urandom), 8'($urandom), 1'($urandom_range(0, 63) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
